// File: rtl/br_param.sv
// Parametrised multi-port integer register bank with a per-register busy scoreboard.
// Optional write-first forwarding is enabled by defining BR_BYPASS_EN.
module br_param #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*XLEN-1:0]  rd,
    output logic [NRD-1:0]       rbusy,
    input  logic [NWR-1:0]       we,
    input  logic [NWR*AW-1:0]    wa,
    input  logic [NWR*XLEN-1:0]  wd,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_a
);

    // No valid/ready handshake: every read, write and reserve is accepted each cycle.
    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           busy;

    // Ascending port order lets the highest-index writer win; the reserve is applied
    // last so a same-cycle reservation outlives the release of the older instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
            busy <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (wa[j*AW +: AW] != '0)) begin
                    regs[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
                    busy[wa[j*AW +: AW]] <= 1'b0;
                end
            end
            if (rsv_en && (rsv_a != '0)) begin
                busy[rsv_a] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            bz;
`ifdef BR_BYPASS_EN
        logic            fwd;
`endif

        assign addr = ra[k*AW +: AW];

        always_comb begin
            data = regs[addr];
            bz   = busy[addr];
`ifdef BR_BYPASS_EN
            fwd  = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (wa[j*AW +: AW] == addr)) begin
                    data = wd[j*XLEN +: XLEN];
                    fwd  = 1'b1;
                end
            end
            // A forwarded write releases the register unless it is re-reserved this cycle.
            if (fwd && !(rsv_en && (rsv_a == addr))) begin
                bz = 1'b0;
            end
`endif
            if (!rst_n || (addr == '0)) begin
                data = '0;
                bz   = 1'b0;
            end
        end

        assign rd[k*XLEN +: XLEN] = data;
        assign rbusy[k]           = bz;
    end

endmodule

// File: tb/tb_br_param.sv
// Scoreboard bench for br_param: a 32-bit/32-reg/2R/2W instance and a 64-bit/16-reg/4R/2W instance.
module tb_br_param;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: XLEN=32, NREGS=32, NRD=2, NWR=2
    logic [9:0]  a_ra;
    logic [63:0] a_rd;
    logic [1:0]  a_rbusy;
    logic [1:0]  a_we;
    logic [9:0]  a_wa;
    logic [63:0] a_wd;
    logic        a_rsv_en;
    logic [4:0]  a_rsv_a;

    // Instance B: XLEN=64, NREGS=16, NRD=4, NWR=2
    logic [15:0]  b_ra;
    logic [255:0] b_rd;
    logic [3:0]   b_rbusy;
    logic [1:0]   b_we;
    logic [7:0]   b_wa;
    logic [127:0] b_wd;
    logic         b_rsv_en;
    logic [3:0]   b_rsv_a;

    br_param #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) u_a (
        .clk(clk), .rst_n(rst_n), .ra(a_ra), .rd(a_rd), .rbusy(a_rbusy),
        .we(a_we), .wa(a_wa), .wd(a_wd), .rsv_en(a_rsv_en), .rsv_a(a_rsv_a)
    );

    br_param #(.XLEN(64), .NREGS(16), .NRD(4), .NWR(2)) u_b (
        .clk(clk), .rst_n(rst_n), .ra(b_ra), .rd(b_rd), .rbusy(b_rbusy),
        .we(b_we), .wa(b_wa), .wd(b_wd), .rsv_en(b_rsv_en), .rsv_a(b_rsv_a)
    );

    // Reference state: plain arrays updated by the architectural rules.
    logic [31:0] ma_reg [32];
    logic        ma_busy[32];
    logic [63:0] mb_reg [16];
    logic        mb_busy[16];

    logic [65:0]  exp_qa[$];
    logic [259:0] exp_qb[$];

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin ma_reg[i] = '0; ma_busy[i] = 1'b0; end
        for (int i = 0; i < 16; i++) begin mb_reg[i] = '0; mb_busy[i] = 1'b0; end
    endtask

    // Drive one cycle on A (called just after a rising edge), queue the expected outputs.
    task automatic a_cycle(input logic [9:0] ra, input logic [1:0] we, input logic [9:0] wa,
                           input logic [63:0] wd, input logic rsv_en, input logic [4:0] rsv_a);
        logic [63:0] e_rd;
        logic [1:0]  e_bz;
        logic [4:0]  a;
`ifdef BR_BYPASS_EN
        logic        hit;
`endif
        a_ra = ra; a_we = we; a_wa = wa; a_wd = wd; a_rsv_en = rsv_en; a_rsv_a = rsv_a;
        for (int k = 0; k < 2; k++) begin
            a = ra[k*5 +: 5];
            e_rd[k*32 +: 32] = ma_reg[a];
            e_bz[k] = ma_busy[a];
`ifdef BR_BYPASS_EN
            hit = 1'b0;
            for (int j = 0; j < 2; j++)
                if (we[j] && wa[j*5 +: 5] == a) begin
                    e_rd[k*32 +: 32] = wd[j*32 +: 32];
                    hit = 1'b1;
                end
            if (hit && !(rsv_en && rsv_a == a)) e_bz[k] = 1'b0;
`endif
            if (a == 5'd0) begin e_rd[k*32 +: 32] = '0; e_bz[k] = 1'b0; end
        end
        exp_qa.push_back({e_bz, e_rd});
        @(posedge clk);
        for (int j = 0; j < 2; j++)
            if (we[j] && wa[j*5 +: 5] != 5'd0) begin
                ma_reg[wa[j*5 +: 5]] = wd[j*32 +: 32];
                ma_busy[wa[j*5 +: 5]] = 1'b0;
            end
        if (rsv_en && rsv_a != 5'd0) ma_busy[rsv_a] = 1'b1;
        #1;
    endtask

    task automatic b_cycle(input logic [15:0] ra, input logic [1:0] we, input logic [7:0] wa,
                           input logic [127:0] wd, input logic rsv_en, input logic [3:0] rsv_a);
        logic [255:0] e_rd;
        logic [3:0]   e_bz;
        logic [3:0]   a;
`ifdef BR_BYPASS_EN
        logic         hit;
`endif
        b_ra = ra; b_we = we; b_wa = wa; b_wd = wd; b_rsv_en = rsv_en; b_rsv_a = rsv_a;
        for (int k = 0; k < 4; k++) begin
            a = ra[k*4 +: 4];
            e_rd[k*64 +: 64] = mb_reg[a];
            e_bz[k] = mb_busy[a];
`ifdef BR_BYPASS_EN
            hit = 1'b0;
            for (int j = 0; j < 2; j++)
                if (we[j] && wa[j*4 +: 4] == a) begin
                    e_rd[k*64 +: 64] = wd[j*64 +: 64];
                    hit = 1'b1;
                end
            if (hit && !(rsv_en && rsv_a == a)) e_bz[k] = 1'b0;
`endif
            if (a == 4'd0) begin e_rd[k*64 +: 64] = '0; e_bz[k] = 1'b0; end
        end
        exp_qb.push_back({e_bz, e_rd});
        @(posedge clk);
        for (int j = 0; j < 2; j++)
            if (we[j] && wa[j*4 +: 4] != 4'd0) begin
                mb_reg[wa[j*4 +: 4]] = wd[j*64 +: 64];
                mb_busy[wa[j*4 +: 4]] = 1'b0;
            end
        if (rsv_en && rsv_a != 4'd0) mb_busy[rsv_a] = 1'b1;
        #1;
    endtask

    // Async reset inside a clock-low window: no edge sees rst_n low, a pending write and
    // reserve on r5 must be lost, and outputs must read zero while reset is held.
    task automatic rst_pulse();
        a_ra = {5'd6, 5'd5}; a_we = 2'b01; a_wa = {5'd0, 5'd5}; a_wd = {32'd0, 32'h1111_1111};
        a_rsv_en = 1'b1; a_rsv_a = 5'd5;
        b_ra = {4'd3, 4'd2, 4'd1, 4'd0}; b_we = '0; b_wa = '0; b_wd = '0; b_rsv_en = 1'b0; b_rsv_a = '0;
        rst_n = 1'b0;
        model_clear();
        exp_qa.push_back('0);
        exp_qb.push_back('0);
        @(negedge clk);
        #2;
        a_we = '0; a_rsv_en = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [65:0]  ea;
        logic [259:0] eb;
        if (exp_qa.size() > 0) begin
            ea = exp_qa.pop_front();
            checks++;
            if ({a_rbusy, a_rd} !== ea) begin
                errors++;
                $display("FAIL dut_a {rbusy,rd} got %h expected %h at %0t", {a_rbusy, a_rd}, ea, $time);
            end
        end
        if (exp_qb.size() > 0) begin
            eb = exp_qb.pop_front();
            checks++;
            if ({b_rbusy, b_rd} !== eb) begin
                errors++;
                $display("FAIL dut_b {rbusy,rd} got %h expected %h at %0t", {b_rbusy, b_rd}, eb, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rb;
        rst_n = 1'b1;
        #1;
        rst_pulse();

        // Reset clear with r5 = DEADBEEF and r6 reserved beforehand
        a_cycle(10'd0, 2'b01, {5'd0, 5'd5}, {32'd0, 32'hDEADBEEF}, 1'b1, 5'd6);
        a_cycle({5'd6, 5'd5}, 2'b00, 10'd0, 64'd0, 1'b0, 5'd0);
        rst_pulse();
        a_cycle({5'd6, 5'd5}, 2'b00, 10'd0, 64'd0, 1'b0, 5'd0);

        // Register 0 ignores writes and reservations
        a_cycle({5'd0, 5'd0}, 2'b01, {5'd0, 5'd0}, {32'd0, 32'h12345678}, 1'b1, 5'd0);
        a_cycle({5'd0, 5'd0}, 2'b00, 10'd0, 64'd0, 1'b0, 5'd0);

        // Same-address write collision
        a_cycle(10'd0, 2'b11, {5'd7, 5'd7}, {32'h5555FFFF, 32'hAAAA0000}, 1'b0, 5'd0);
        a_cycle({5'd0, 5'd7}, 2'b00, 10'd0, 64'd0, 1'b0, 5'd0);

        // Busy scoreboard: reserve, release, reserve+write together
        a_cycle(10'd0, 2'b00, 10'd0, 64'd0, 1'b1, 5'd9);
        a_cycle({5'd9, 5'd9}, 2'b00, 10'd0, 64'd0, 1'b0, 5'd0);
        a_cycle({5'd9, 5'd0}, 2'b01, {5'd0, 5'd9}, {32'd0, 32'h42}, 1'b0, 5'd0);
        a_cycle({5'd9, 5'd9}, 2'b00, 10'd0, 64'd0, 1'b0, 5'd0);
        a_cycle({5'd9, 5'd0}, 2'b10, {5'd9, 5'd0}, {32'h77, 32'd0}, 1'b1, 5'd9);
        a_cycle({5'd9, 5'd9}, 2'b00, 10'd0, 64'd0, 1'b0, 5'd0);

        // Same-cycle write and read of r3
        a_cycle(10'd0, 2'b01, {5'd0, 5'd3}, {32'd0, 32'h1}, 1'b0, 5'd0);
        a_cycle({5'd3, 5'd0}, 2'b01, {5'd0, 5'd3}, {32'd0, 32'hCAFEF00D}, 1'b0, 5'd0);
        a_cycle({5'd3, 5'd3}, 2'b00, 10'd0, 64'd0, 1'b0, 5'd0);

        // Random traffic on A over a narrow address window to provoke collisions
        for (int i = 0; i < 300; i++)
            a_cycle({5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
                    2'($urandom_range(0, 3)),
                    {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
                    {$urandom, $urandom},
                    ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));

        // Parameter sweep on B: distinct patterns in r1..r15, then random multi-port reads
        for (int i = 1; i <= 15; i += 2)
            b_cycle(16'd0, (i == 15) ? 2'b01 : 2'b11,
                    {4'(i + 1), 4'(i)},
                    {32'hB0B0_0000 + 32'(i + 1), ~32'(i + 1), 32'hB0B0_0000 + 32'(i), ~32'(i)},
                    1'b0, 4'd0);
        for (int i = 0; i < 40; i++) begin
            rb = 16'($urandom);
            b_cycle(rb, 2'b00, 8'd0, 128'd0, 1'b0, 4'd0);
        end
        for (int i = 0; i < 200; i++)
            b_cycle(16'($urandom), 2'($urandom_range(0, 3)), 8'($urandom),
                    {$urandom, $urandom, $urandom, $urandom},
                    ($urandom_range(0, 2) == 0), 4'($urandom));

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_qa.size() != 0 || exp_qb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending expected 0/0", exp_qa.size(), exp_qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
